// File: rtl/gnn_top.sv
// gnn_top: four-node, two-layer neural inference block.
// Each node multiplies its 4-element feature vector by a shared 4x4 hidden
// weight set. It applies ReLU, then multiplies the hidden vector by a shared
// 4x2 output weight set. The pipeline has three register stages: inputs,
// hidden units and outputs. It accepts one sample per cycle.
// Ports:
//   clk                    rising-edge clock
//   rst_n                  synchronous reset, active HIGH (1 = reset)
//   in_ready               input-valid strobe; inputs sampled when 1
//   xI_nodeN               signed features (DW bits), I=0..3, N=0..3
//   wIJ (J=4..7)           signed layer-1 weights, feature I -> hidden J
//   wJK (K=8,9)            signed layer-2 weights, hidden J -> output K
//   out0_nodeN/out1_nodeN  signed results y8/y9 of node N (OW bits)
//   out10_/out11_ready_nodeN  valid flags of the results (always equal)
module gnn_top #(
  parameter int DW  = 5,
  parameter int OW  = 21,
  parameter int LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_ready,
  input  logic [DW-1:0] x0_node0, x1_node0, x2_node0, x3_node0,
  input  logic [DW-1:0] x0_node1, x1_node1, x2_node1, x3_node1,
  input  logic [DW-1:0] x0_node2, x1_node2, x2_node2, x3_node2,
  input  logic [DW-1:0] x0_node3, x1_node3, x2_node3, x3_node3,
  input  logic [DW-1:0] w04, w14, w24, w34,
  input  logic [DW-1:0] w05, w15, w25, w35,
  input  logic [DW-1:0] w06, w16, w26, w36,
  input  logic [DW-1:0] w07, w17, w27, w37,
  input  logic [DW-1:0] w48, w58, w68, w78,
  input  logic [DW-1:0] w49, w59, w69, w79,
  output logic [OW-1:0] out0_node0, out1_node0,
  output logic [OW-1:0] out0_node1, out1_node1,
  output logic [OW-1:0] out0_node2, out1_node2,
  output logic [OW-1:0] out0_node3, out1_node3,
  output logic          out10_ready_node0, out11_ready_node0,
  output logic          out10_ready_node1, out11_ready_node1,
  output logic          out10_ready_node2, out11_ready_node2,
  output logic          out10_ready_node3, out11_ready_node3
);

  localparam int PW1 = 2 * DW;    // layer-1 product width
  localparam int SW  = PW1 + 2;   // layer-1 sum / hidden width
  localparam int PW2 = SW + DW;   // layer-2 product width

  // Hidden unit: 4-term dot product followed by ReLU.
  function automatic logic [SW-1:0] hidden_f(input logic [4*DW-1:0] x,
                                             input logic [4*DW-1:0] w);
    logic signed [PW1-1:0] prod;
    logic signed [SW-1:0]  acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      prod = PW1'($signed(x[i*DW +: DW])) * PW1'($signed(w[i*DW +: DW]));
      acc  = acc + SW'(prod);
    end
    return acc[SW-1] ? {SW{1'b0}} : acc;
  endfunction

  // Output unit: 4-term dot product; the hidden values are non-negative.
  function automatic logic [OW-1:0] output_f(input logic [4*SW-1:0] h,
                                             input logic [4*DW-1:0] w);
    logic signed [PW2-1:0] prod;
    logic signed [OW-1:0]  acc;
    acc = '0;
    for (int j = 0; j < 4; j++) begin
      prod = PW2'($signed(h[j*SW +: SW])) * PW2'($signed(w[j*DW +: DW]));
      acc  = acc + OW'(prod);
    end
    return acc;
  endfunction

  // Input vectors packed with element 0 in the least significant slot.
  logic [4*DW-1:0] x_in_s  [4];
  logic [4*DW-1:0] w1_in_s [4];   // per hidden unit, indexed by feature
  logic [4*DW-1:0] w2_in_s [2];   // per output, indexed by hidden unit

  assign x_in_s[0]  = {x3_node0, x2_node0, x1_node0, x0_node0};
  assign x_in_s[1]  = {x3_node1, x2_node1, x1_node1, x0_node1};
  assign x_in_s[2]  = {x3_node2, x2_node2, x1_node2, x0_node2};
  assign x_in_s[3]  = {x3_node3, x2_node3, x1_node3, x0_node3};
  assign w1_in_s[0] = {w34, w24, w14, w04};
  assign w1_in_s[1] = {w35, w25, w15, w05};
  assign w1_in_s[2] = {w36, w26, w16, w06};
  assign w1_in_s[3] = {w37, w27, w17, w07};
  assign w2_in_s[0] = {w78, w68, w58, w48};
  assign w2_in_s[1] = {w79, w69, w59, w49};

  logic [LAT-1:0]  vld_r;          // bit s = stage s+1 holds a valid sample
  logic [4*DW-1:0] x_r     [4];
  logic [4*DW-1:0] w1_r    [4];
  logic [4*DW-1:0] w2_r    [2];
  logic [4*DW-1:0] w2_s2_r [2];    // layer-2 weights travelling with h_r
  logic [4*SW-1:0] h_s     [4];
  logic [4*SW-1:0] h_r     [4];
  logic [OW-1:0]   y_s     [4][2];
  logic [OW-1:0]   y_r     [4][2];

  // Valid pipeline: shifts in_ready through the three stages.
  always_ff @(posedge clk) begin
    if (rst_n) vld_r <= '0;
    else       vld_r <= {vld_r[LAT-2:0], in_ready};
  end

  // Stage 1: capture features and weights on accepted samples.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int n = 0; n < 4; n++) x_r[n]  <= '0;
      for (int j = 0; j < 4; j++) w1_r[j] <= '0;
      for (int k = 0; k < 2; k++) w2_r[k] <= '0;
    end else if (in_ready) begin
      for (int n = 0; n < 4; n++) x_r[n]  <= x_in_s[n];
      for (int j = 0; j < 4; j++) w1_r[j] <= w1_in_s[j];
      for (int k = 0; k < 2; k++) w2_r[k] <= w2_in_s[k];
    end
  end

  // Stage 2 datapath: hidden units of every node.
  always_comb begin
    for (int n = 0; n < 4; n++) h_s[n] = '0;
    for (int n = 0; n < 4; n++)
      for (int j = 0; j < 4; j++)
        h_s[n][j*SW +: SW] = hidden_f(x_r[n], w1_r[j]);
  end

  // Stage 2 registers: hidden values plus the weights stage 3 will need.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int n = 0; n < 4; n++) h_r[n]     <= '0;
      for (int k = 0; k < 2; k++) w2_s2_r[k] <= '0;
    end else if (vld_r[0]) begin
      for (int n = 0; n < 4; n++) h_r[n]     <= h_s[n];
      for (int k = 0; k < 2; k++) w2_s2_r[k] <= w2_r[k];
    end
  end

  // Stage 3 datapath: output units of every node.
  always_comb begin
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++)
        y_s[n][k] = '0;
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++)
        y_s[n][k] = output_f(h_r[n], w2_s2_r[k]);
  end

  // Stage 3 registers: results hold until the next valid sample arrives.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 2; k++)
          y_r[n][k] <= '0;
    end else if (vld_r[1]) begin
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 2; k++)
          y_r[n][k] <= y_s[n][k];
    end
  end

  assign out0_node0 = y_r[0][0];
  assign out1_node0 = y_r[0][1];
  assign out0_node1 = y_r[1][0];
  assign out1_node1 = y_r[1][1];
  assign out0_node2 = y_r[2][0];
  assign out1_node2 = y_r[2][1];
  assign out0_node3 = y_r[3][0];
  assign out1_node3 = y_r[3][1];

  assign out10_ready_node0 = vld_r[LAT-1];
  assign out11_ready_node0 = vld_r[LAT-1];
  assign out10_ready_node1 = vld_r[LAT-1];
  assign out11_ready_node1 = vld_r[LAT-1];
  assign out10_ready_node2 = vld_r[LAT-1];
  assign out11_ready_node2 = vld_r[LAT-1];
  assign out10_ready_node3 = vld_r[LAT-1];
  assign out11_ready_node3 = vld_r[LAT-1];

endmodule

// File: tb/tb_gnn_top.sv
// Self-checking bench for gnn_top: directed vector table, handshake and
// reset sequences, and a randomized stream checked against an integer model.
module tb_gnn_top;

  localparam int NR = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_ready;
  logic [4:0]  x_p  [4][4];   // [node][feature]
  logic [4:0]  w1_p [4][4];   // [feature i][hidden j-4]
  logic [4:0]  w2_p [4][2];   // [hidden j-4][output k-8]
  logic [20:0] o0 [4];
  logic [20:0] o1 [4];
  logic        r10 [4];
  logic        r11 [4];

  int xi  [4][4];
  int w1i [4][4];
  int w2i [4][2];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0][3:0][4:0] x;    // [node][feature]
    logic [3:0][3:0][4:0] w1;   // [hidden j-4][feature]
    logic [1:0][3:0][4:0] w2;   // [output k-8][hidden j-4]
    logic [3:0][20:0]     e0;   // expected out0 per node
    logic [3:0][20:0]     e1;   // expected out1 per node
  } vec_t;

  vec_t vecs [4];

  logic [3:0][20:0] zero4;
  logic [3:0][20:0] cur0, cur1;
  logic [3:0][20:0] ev0 [NR];
  logic [3:0][20:0] ev1 [NR];
  logic             acc_a [NR];

  always #5 clk = ~clk;

  gnn_top dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready),
    .x0_node0(x_p[0][0]), .x1_node0(x_p[0][1]), .x2_node0(x_p[0][2]), .x3_node0(x_p[0][3]),
    .x0_node1(x_p[1][0]), .x1_node1(x_p[1][1]), .x2_node1(x_p[1][2]), .x3_node1(x_p[1][3]),
    .x0_node2(x_p[2][0]), .x1_node2(x_p[2][1]), .x2_node2(x_p[2][2]), .x3_node2(x_p[2][3]),
    .x0_node3(x_p[3][0]), .x1_node3(x_p[3][1]), .x2_node3(x_p[3][2]), .x3_node3(x_p[3][3]),
    .w04(w1_p[0][0]), .w14(w1_p[1][0]), .w24(w1_p[2][0]), .w34(w1_p[3][0]),
    .w05(w1_p[0][1]), .w15(w1_p[1][1]), .w25(w1_p[2][1]), .w35(w1_p[3][1]),
    .w06(w1_p[0][2]), .w16(w1_p[1][2]), .w26(w1_p[2][2]), .w36(w1_p[3][2]),
    .w07(w1_p[0][3]), .w17(w1_p[1][3]), .w27(w1_p[2][3]), .w37(w1_p[3][3]),
    .w48(w2_p[0][0]), .w58(w2_p[1][0]), .w68(w2_p[2][0]), .w78(w2_p[3][0]),
    .w49(w2_p[0][1]), .w59(w2_p[1][1]), .w69(w2_p[2][1]), .w79(w2_p[3][1]),
    .out0_node0(o0[0]), .out1_node0(o1[0]),
    .out0_node1(o0[1]), .out1_node1(o1[1]),
    .out0_node2(o0[2]), .out1_node2(o1[2]),
    .out0_node3(o0[3]), .out1_node3(o1[3]),
    .out10_ready_node0(r10[0]), .out11_ready_node0(r11[0]),
    .out10_ready_node1(r10[1]), .out11_ready_node1(r11[1]),
    .out10_ready_node2(r10[2]), .out11_ready_node2(r11[2]),
    .out10_ready_node3(r10[3]), .out11_ready_node3(r11[3])
  );

  function automatic logic [3:0][4:0] pk4(input int a, input int b, input int c, input int d);
    logic [3:0][4:0] r;
    r[0] = a[4:0]; r[1] = b[4:0]; r[2] = c[4:0]; r[3] = d[4:0];
    return r;
  endfunction

  function automatic logic [3:0][20:0] pe4(input int a, input int b, input int c, input int d);
    logic [3:0][20:0] r;
    r[0] = a[20:0]; r[1] = b[20:0]; r[2] = c[20:0]; r[3] = d[20:0];
    return r;
  endfunction

  task automatic drive_ports();
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) x_p[n][i] = 5'(xi[n][i]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w1_p[i][j] = 5'(w1i[i][j]);
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 2; k++) w2_p[j][k] = 5'(w2i[j][k]);
  endtask

  task automatic randomize_inputs();
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) xi[n][i] = int'($urandom_range(31, 0)) - 16;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w1i[i][j] = int'($urandom_range(31, 0)) - 16;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 2; k++) w2i[j][k] = int'($urandom_range(31, 0)) - 16;
    drive_ports();
  endtask

  task automatic load_vec(input vec_t v);
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) xi[n][i] = $signed(v.x[n][i]);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) w1i[i][j] = $signed(v.w1[j][i]);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++) w2i[j][k] = $signed(v.w2[k][j]);
    drive_ports();
  endtask

  // Reference: plain integer dot products with ReLU on the hidden layer.
  task automatic model(output logic [3:0][20:0] e0, output logic [3:0][20:0] e1);
    int h [4];
    int s;
    int y0;
    int y1;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int i = 0; i < 4; i++) s += xi[n][i] * w1i[i][j];
        h[j] = (s < 0) ? 0 : s;
      end
      y0 = 0;
      y1 = 0;
      for (int j = 0; j < 4; j++) begin
        y0 += h[j] * w2i[j][0];
        y1 += h[j] * w2i[j][1];
      end
      e0[n] = 21'(y0);
      e1[n] = 21'(y1);
    end
  endtask

  task automatic check_outs(input string nm, input logic rdy,
                            input logic [3:0][20:0] e0, input logic [3:0][20:0] e1);
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (o0[n] !== e0[n]) begin
        n_errors++;
        $display("FAIL %s node%0d out0: got %0d, expected %0d", nm, n, $signed(o0[n]), $signed(e0[n]));
      end
      n_checks++;
      if (o1[n] !== e1[n]) begin
        n_errors++;
        $display("FAIL %s node%0d out1: got %0d, expected %0d", nm, n, $signed(o1[n]), $signed(e1[n]));
      end
      n_checks++;
      if (r10[n] !== rdy || r11[n] !== rdy) begin
        n_errors++;
        $display("FAIL %s node%0d ready: got %b/%b, expected %b", nm, n, r10[n], r11[n], rdy);
      end
    end
  endtask

  initial begin
    zero4 = '0;
    // Mixed-sign vector with hand-derived results.
    vecs[0].x[0]  = pk4(4, 2, 4, 1);
    vecs[0].x[1]  = pk4(6, 4, 4, 1);
    vecs[0].x[2]  = pk4(8, 6, 4, 1);
    vecs[0].x[3]  = pk4(6, 4, 4, 1);
    vecs[0].w1[0] = pk4(3, 2, 13, -6);
    vecs[0].w1[1] = pk4(-9, 1, -4, 14);
    vecs[0].w1[2] = pk4(3, 6, -15, 15);
    vecs[0].w1[3] = pk4(9, -10, 15, -10);
    vecs[0].w2[0] = pk4(0, -1, 3, -11);
    vecs[0].w2[1] = pk4(-12, -15, -15, 6);
    vecs[0].e0    = pe4(-726, -704, -637, -704);
    vecs[0].e1    = pe4(-348, -480, -837, -480);
    // All zero, all max, all min.
    for (int v = 1; v < 4; v++) begin
      for (int n = 0; n < 4; n++) begin
        vecs[v].x[n]  = (v == 1) ? pk4(0, 0, 0, 0) : (v == 2) ? pk4(15, 15, 15, 15) : pk4(-16, -16, -16, -16);
        vecs[v].w1[n] = vecs[v].x[n];
      end
      vecs[v].w2[0] = vecs[v].x[0];
      vecs[v].w2[1] = vecs[v].x[0];
    end
    vecs[1].e0 = pe4(0, 0, 0, 0);
    vecs[1].e1 = pe4(0, 0, 0, 0);
    vecs[2].e0 = pe4(54000, 54000, 54000, 54000);
    vecs[2].e1 = pe4(54000, 54000, 54000, 54000);
    vecs[3].e0 = pe4(-65536, -65536, -65536, -65536);
    vecs[3].e1 = pe4(-65536, -65536, -65536, -65536);

    // Reset with random inputs and in_ready high: reset wins.
    rst_n    = 1'b1;
    in_ready = 1'b1;
    randomize_inputs();
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, zero4, zero4);
    rst_n    = 1'b0;
    in_ready = 1'b0;

    // Table vectors with in_ready held high.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      load_vec(vecs[v]);
      in_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_outs($sformatf("vec%0d", v), 1'b1, vecs[v].e0, vecs[v].e1);
    end

    // in_ready falls: flags stay for one more edge, then drop; values hold.
    in_ready = 1'b0;
    randomize_inputs();
    @(negedge clk);
    @(negedge clk);
    check_outs("drop_e2", 1'b1, vecs[3].e0, vecs[3].e1);
    @(negedge clk);
    check_outs("drop_e3", 1'b0, vecs[3].e0, vecs[3].e1);

    // Single-cycle in_ready pulse.
    load_vec(vecs[0]);
    in_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_ready = 1'b0;
      randomize_inputs();
      if (c < 2) check_outs($sformatf("pulse_c%0d", c), 1'b0, vecs[3].e0, vecs[3].e1);
      else       check_outs($sformatf("pulse_c%0d", c), (c == 2), vecs[0].e0, vecs[0].e1);
    end

    // Reset one cycle after an accepted sample squashes it.
    load_vec(vecs[2]);
    in_ready = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    in_ready = 1'b0;
    randomize_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_outs($sformatf("midrst_c%0d", c), 1'b0, zero4, zero4);
      @(negedge clk);
    end

    // Randomized stream: ready for edge s reflects acceptance at edge s-2.
    cur0 = '0;
    cur1 = '0;
    for (int t = 0; t <= NR; t++) begin
      if (t > 0) @(negedge clk);
      if (t >= 1) begin
        if (t >= 3 && acc_a[t-3]) begin
          cur0 = ev0[t-3];
          cur1 = ev1[t-3];
        end
        check_outs("random", (t >= 3) ? acc_a[t-3] : 1'b0, cur0, cur1);
      end
      if (t < NR) begin
        randomize_inputs();
        in_ready = ($urandom_range(9, 0) < 7);
        acc_a[t] = in_ready;
        model(ev0[t], ev1[t]);
      end else begin
        in_ready = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gnn_top.md
Name: gnn_top

Overview:
- Four-node, two-layer neural inference block.
- Each node has a 4-element feature vector x0..x3. All nodes share one 4x4 hidden-layer weight set (hidden units 4..7) and one 4x2 output-layer weight set (outputs 8, 9).
- Per node, it produces two signed results with ready flags.
- Sits between the feature/weight register file and downstream result consumers; the four node datapaths are identical and independent.

Parameters:
- DW, 5, width of features and weights (two's complement)
- OW, 21, width of each output result (two's complement)
- LAT, 3, cycles from an accepted input to outputs valid

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-high reset; the name is kept as in the codebase, and 1 = reset
- in_ready  input  1  input-valid strobe; inputs are sampled on every rising clk with in_ready=1
- x0_nodeN..x3_nodeN (N=0..3)  input  DW each  signed features of node N
- w04,w14,w24,w34 / w05..w35 / w06..w36 / w07..w37  input  DW each  signed layer-1 weights; wij connects feature i to hidden unit j
- w48,w58,w68,w78 / w49,w59,w69,w79  input  DW each  signed layer-2 weights; wjk connects hidden unit j to output k
- out0_nodeN, out1_nodeN (N=0..3)  output  OW each  signed results k=8 and k=9 for node N
- out10_ready_nodeN, out11_ready_nodeN (N=0..3)  output  1  valid flags for out0_nodeN and out1_nodeN

Behaviour:
- Reset: when rst_n=1 at a rising edge, all pipeline registers, all outputs and all ready flags become 0. Reset overrides in_ready and squashes in-flight samples.
- Stage 1 (edge with in_ready=1): register all 16 features and 24 weights. With in_ready=0, the stage-1 valid bit clears and the registers hold.
- Stage 2, per node, hidden unit j=4..7:
  - h_j = ReLU(sum over i of x_i*w_ij).
  - Products are 10-bit signed; the sum is 12-bit signed.
  - ReLU: a negative sum gives 0.
  - Register h_j plus a valid bit.
- Stage 3, per node, output k=8,9:
  - y_k = sum over j of h_j*w_jk, with no activation.
  - Products are 17-bit signed; the sum is sign-extended to OW.
  - Register y_k and set both ready flags.
- Latency: inputs sampled at edge E give outputs and ready flags updated at edge E+2, visible during cycle E+2 to E+3 (LAT=3 counting the sampling edge).
- Fully pipelined: with in_ready held high, a new sample is accepted every cycle and the outputs track the inputs at throughput 1.
- Ready flags equal the stage-3 valid bit. A flag is 1 for each cycle whose output came from an accepted sample, and drops to 0 two edges after in_ready falls.
- out0/out1 hold their last computed value while the ready flags are 0; they change only when a new valid sample reaches stage 3 or on reset.
- out10_ready and out11_ready of all nodes are always equal; they are separate ports for downstream compatibility.
- No overflow is possible:
  - |h| ≤ 1024 (all inputs -16).
  - |y| ≤ 65536, which fits 21 bits; no saturation logic is required.
- Inputs changing while in_ready=0 have no effect on the outputs.

Test Plan:
- Reset: hold rst_n=1 for 1 cycle with random inputs -> all outputs 0, all ready flags 0.
- Mixed signs (expected hidden: node0 h=62,0,0,66; node2 h=82,0,15,62):
  - Stimulus: node0 x=(4,2,4,1), node1/node3 x=(6,4,4,1), node2 x=(8,6,4,1).
  - Layer-1 weights: w04..w34=(3,2,13,-6), w05..w35=(-9,1,-4,14), w06..w36=(3,6,-15,15), w07..w37=(9,-10,15,-10).
  - Layer-2 weights: w48..w78=(0,-1,3,-11), w49..w79=(-12,-15,-15,6). Hold in_ready=1.
  - Required: out0 = -726, -704, -637, -704 and out1 = -348, -480, -837, -480 for nodes 0..3.
- Maximum: all x and w = 15, in_ready=1 -> every out0/out1 = 54000, ready flags = 1.
- Minimum: all x and w = -16 -> hidden = 1024, every out0/out1 = -65536.
- Handshake:
  - Single-cycle in_ready pulse -> ready flags high for exactly 1 cycle, at edge +2.
  - Changing inputs while in_ready=0 -> outputs unchanged.
- Mid-operation reset: assert rst_n one cycle after an accepted sample -> no ready pulse; outputs stay 0.
